// File: rtl/scroll_animator.sv
// scroll_animator: steps a signed horizontal scroll offset at most once per frame, latched on the vsync falling edge.
// Build option `SCROLL_PINGPONG_EN: bounce between OFFSET_MIN and OFFSET_MAX instead of wrapping to OFFSET_MAX.
module scroll_animator #(
  parameter int OFFSET_W        = 12,
  parameter int OFFSET_MIN      = -600,
  parameter int OFFSET_MAX      = 600,
  parameter int FRAMES_PER_STEP = 1,
  parameter int DIV_W           = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vsync,
  input  logic                       enable,
  input  logic                       restart,
  input  logic [3:0]                 speed,
  output logic signed [OFFSET_W-1:0] hoffset,
  output logic                       frame_tick,
  output logic                       wrap,
  output logic                       running
);
  // state | meaning
  // IDLE  | after reset, offset parked at OFFSET_MAX
  // RUN   | offset steps on frame boundaries through the divider
  // PAUSE | offset and divider frozen, boundaries still ticked
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam int XW = OFFSET_W + 1;
  localparam logic signed [OFFSET_W-1:0] MAX_O    = OFFSET_W'(OFFSET_MAX);
  localparam logic signed [XW-1:0]       MIN_X    = XW'(OFFSET_MIN);
  localparam logic [DIV_W-1:0]           DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);

  state_t state_q, state_d;
  logic vsync_q, restart_pend;
  logic [DIV_W-1:0] div_q, div_d;
  logic boundary, restart_hit;
  logic signed [XW-1:0] cur_x, spd_x, dec_x;
  logic signed [OFFSET_W-1:0] hoffset_d;
  logic wrap_d, running_d;

`ifdef SCROLL_PINGPONG_EN
  localparam logic signed [OFFSET_W-1:0] MIN_O = OFFSET_W'(OFFSET_MIN);
  localparam logic signed [XW-1:0]       MAX_X = XW'(OFFSET_MAX);
  logic dir_q, dir_d;
  logic signed [XW-1:0] inc_x;
  assign inc_x = cur_x + spd_x;
`endif

  assign boundary    = vsync_q & ~vsync;
  assign restart_hit = boundary & (restart_pend | restart);
  // one extra bit of headroom so hoffset +/- speed never overflows
  assign cur_x = {hoffset[OFFSET_W-1], hoffset};
  assign spd_x = XW'(speed);
  assign dec_x = cur_x - spd_x;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = PAUSE;
      PAUSE:   if (enable)  state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hoffset_d = hoffset;
    div_d     = div_q;
    wrap_d    = 1'b0;
    running_d = (state_d == RUN);
`ifdef SCROLL_PINGPONG_EN
    dir_d = dir_q;
`endif
    if (restart_hit) begin
      hoffset_d = MAX_O;
      div_d     = '0;
`ifdef SCROLL_PINGPONG_EN
      dir_d = 1'b0;
`endif
    end else if (boundary && state_q == RUN) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
`ifdef SCROLL_PINGPONG_EN
        if (dir_q) begin
          if (inc_x > MAX_X) begin
            hoffset_d = MAX_O;
            dir_d     = 1'b0;
            wrap_d    = 1'b1;
          end else begin
            hoffset_d = inc_x[OFFSET_W-1:0];
          end
        end else begin
          if (dec_x < MIN_X) begin
            hoffset_d = MIN_O;
            dir_d     = 1'b1;
            wrap_d    = 1'b1;
          end else begin
            hoffset_d = dec_x[OFFSET_W-1:0];
          end
        end
`else
        if (dec_x < MIN_X) begin
          hoffset_d = MAX_O;
          wrap_d    = 1'b1;
        end else begin
          hoffset_d = dec_x[OFFSET_W-1:0];
        end
`endif
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q      <= 1'b1;
      restart_pend <= 1'b0;
      div_q        <= '0;
      hoffset      <= MAX_O;
      frame_tick   <= 1'b0;
      wrap         <= 1'b0;
      running      <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      restart_pend <= boundary ? 1'b0 : (restart_pend | restart);
      div_q        <= div_d;
      hoffset      <= hoffset_d;
      frame_tick   <= boundary;
      wrap         <= wrap_d;
      running      <= running_d;
    end
  end

`ifdef SCROLL_PINGPONG_EN
  always_ff @(posedge clk) begin
    if (rst) dir_q <= 1'b0;
    else     dir_q <= dir_d;
  end
`endif

endmodule

// File: tb/tb_scroll_animator.sv
// Bench for scroll_animator: two instances (one step per frame, one step per three frames)
// with a queue of expected per-boundary results checked by a decoupled monitor.
module tb_scroll_animator;
  typedef struct {
    int hoff;
    bit wrap;
    bit run;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, vsync, enable, restart, mid;
  logic [3:0] spd0, spd1;
  logic signed [11:0] hoff0, hoff1;
  logic tick0, tick1, wrap0, wrap1, run0, run1;
  logic [1:0] rst_seen = 2'b00;

  exp_t q0[$];
  exp_t q1[$];
  int cur[2];
  int n_checks = 0;
  int n_pass = 0;

`ifdef SCROLL_PINGPONG_EN
  localparam int WRAP_H = -600, AFTER1 = -597, AFTER2 = -594;
`else
  localparam int WRAP_H = 600, AFTER1 = 597, AFTER2 = 594;
`endif

  scroll_animator #(.OFFSET_W(12), .OFFSET_MIN(-600), .OFFSET_MAX(600),
                    .FRAMES_PER_STEP(1), .DIV_W(8)) u_dut0 (
    .clk(clk), .rst(rst[0]), .vsync(vsync[0]), .enable(enable[0]),
    .restart(restart[0]), .speed(spd0), .hoffset(hoff0),
    .frame_tick(tick0), .wrap(wrap0), .running(run0)
  );

  scroll_animator #(.OFFSET_W(12), .OFFSET_MIN(-600), .OFFSET_MAX(600),
                    .FRAMES_PER_STEP(3), .DIV_W(8)) u_dut1 (
    .clk(clk), .rst(rst[1]), .vsync(vsync[1]), .enable(enable[1]),
    .restart(restart[1]), .speed(spd1), .hoffset(hoff1),
    .frame_tick(tick1), .wrap(wrap1), .running(run1)
  );

  always @(posedge clk) rst_seen <= rst;

  task automatic chk(input int d, input string nm, input integer got, input integer exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL dut%0d %s: got %0d expected %0d", d, nm, got, exp);
  endtask

  task automatic observe(input int d, input logic tick, input logic signed [11:0] h,
                         input logic w, input logic r, input logic rs, input logic mc);
    exp_t e;
    bit have;
    if (rs) begin
      chk(d, "reset hoffset", h, 600);
      chk(d, "reset running", r, 0);
      chk(d, "reset frame_tick", tick, 0);
      chk(d, "reset wrap", w, 0);
      cur[d] = 600;
    end else if (tick) begin
      have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (!have) begin
        n_checks++;
        $display("FAIL dut%0d frame_tick: got unexpected pulse, expected none", d);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk(d, "boundary hoffset", h, e.hoff);
        chk(d, "boundary wrap", w, e.wrap);
        chk(d, "boundary running", r, e.run);
        cur[d] = e.hoff;
      end
    end else if (mc) begin
      chk(d, "midframe hoffset", h, cur[d]);
      chk(d, "midframe wrap", w, 0);
    end
  endtask

  always @(negedge clk) begin
    observe(0, tick0, hoff0, wrap0, run0, rst_seen[0], mid[0]);
    observe(1, tick1, hoff1, wrap1, run1, rst_seen[1], mid[1]);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // rm: 0 none, 1 restart pulse mid-frame, 2 restart coincident with the boundary
  task automatic frame(input int d, input int h, input bit w, input bit r,
                       input int rm, input bit rmid);
    exp_t e;
    e.hoff = h; e.wrap = w; e.run = r;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    vsync[d] = 1'b0;
    if (rm == 2) restart[d] = 1'b1;
    cyc(1); restart[d] = 1'b0;
    cyc(1); vsync[d] = 1'b1;
    cyc(1);
    if (rm == 1) restart[d] = 1'b1;
    if (rmid) rst[d] = 1'b1;
    cyc(1); restart[d] = 1'b0; rst[d] = 1'b0;
    cyc(1); mid[d] = 1'b1;
    cyc(1); mid[d] = 1'b0;
    cyc(4);
  endtask

  initial begin
    rst = 2'b11; vsync = 2'b11; enable = 2'b00; restart = 2'b00; mid = 2'b00;
    spd0 = 4'd0; spd1 = 4'd0;
    cur[0] = 600; cur[1] = 600;
    cyc(3); rst = 2'b00;
    cyc(2);

    for (int i = 0; i < 5; i++) frame(0, 600, 0, 0, 0, 0);

    enable[0] = 1'b1; spd0 = 4'd1; cyc(2);
    frame(0, 599, 0, 1, 0, 0);
    frame(0, 598, 0, 1, 0, 0);
    frame(0, 597, 0, 1, 0, 0);

    spd0 = 4'd15;
    for (int i = 1; i <= 79; i++) frame(0, 597 - 15 * i, 0, 1, 0, 0);
    spd0 = 4'd10; frame(0, -598, 0, 1, 0, 0);
    spd0 = 4'd2;  frame(0, -600, 0, 1, 0, 0);
    spd0 = 4'd0;  frame(0, -600, 0, 1, 0, 0);
    frame(0, -600, 0, 1, 1, 0);
    spd0 = 4'd10; frame(0, 600, 0, 1, 0, 0);

    for (int i = 1; i <= 50; i++) frame(0, 600 - 10 * i, 0, 1, (i == 50) ? 1 : 0, 0);
    frame(0, 600, 0, 1, 0, 0);

    spd0 = 4'd15;
    for (int i = 1; i <= 79; i++) frame(0, 600 - 15 * i, 0, 1, 0, 0);
    spd0 = 4'd14; frame(0, -599, 0, 1, 0, 0);
    spd0 = 4'd3;  frame(0, WRAP_H, 1, 1, 0, 0);
    frame(0, AFTER1, 0, 1, 0, 0);
    frame(0, AFTER2, 0, 1, 0, 0);
    frame(0, 600, 0, 1, 2, 0);
    frame(0, 597, 0, 1, 0, 0);
    frame(0, 594, 0, 1, 0, 1);
    frame(0, 597, 0, 1, 0, 0);

    enable[1] = 1'b1; spd1 = 4'd5; cyc(2);
    frame(1, 600, 0, 1, 0, 0);
    frame(1, 600, 0, 1, 0, 0);
    frame(1, 595, 0, 1, 0, 0);
    frame(1, 595, 0, 1, 0, 0);
    enable[1] = 1'b0; cyc(2);
    frame(1, 595, 0, 0, 0, 0);
    frame(1, 595, 0, 0, 0, 0);
    enable[1] = 1'b1; cyc(2);
    frame(1, 595, 0, 1, 0, 0);
    frame(1, 590, 0, 1, 0, 0);

    cyc(3);
    chk(0, "unconsumed expectations", q0.size(), 0);
    chk(1, "unconsumed expectations", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/scroll_animator.md
# scroll_animator

Frame-synchronous scroll-offset generator that drives the `hoffset` input of a layer transformer in the video pipeline. It watches the VGA timing generator's `vsync`, and at most once per frame steps a signed horizontal offset across a configured range. The offset is held constant for the whole visible frame, which prevents tearing, and it wraps when it leaves the range. It replaces free-running divided-clock animation with a single-clock, enable-based design.

## Interface
Parameters:
- `OFFSET_W`, 12: width of signed offset output
- `OFFSET_MIN`, -600: lowest legal offset (signed)
- `OFFSET_MAX`, 600: highest legal offset and start value (signed); `OFFSET_MIN < OFFSET_MAX` required
- `FRAMES_PER_STEP`, 1: frame ticks per offset update, ≥1
- `DIV_W`, 8: width of frame divider counter

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  pixel-domain clock, same clock as the VGA timing generator
- `rst`  in  1  synchronous, active-high reset
- `vsync`  in  1  VGA vertical sync, active-low; its falling edge marks the frame boundary
- `enable`  in  1  level; 1 = animate, 0 = pause
- `restart`  in  1  single-cycle pulse; requests return to `OFFSET_MAX`
- `speed`  in  4  unsigned step magnitude per update; 0 = hold
- `hoffset`  out  OFFSET_W  signed offset for the transformer
- `frame_tick`  out  1  one-cycle pulse, registered, once per detected frame boundary
- `wrap`  out  1  one-cycle pulse coincident with a wrap or reversal update
- `running`  out  1  1 while in the RUN state

## Operation
- Edge detect: `vsync_q` is the previous-cycle `vsync`. A boundary occurs when `vsync_q==1 && vsync==0`.
- FSM states:
  - IDLE: entered on reset. The offset is held at `OFFSET_MAX`. `enable==1` moves to RUN.
  - RUN: stepping. `enable==0` moves to PAUSE.
  - PAUSE: the offset is held. `enable==1` moves to RUN.
- State transitions are evaluated every cycle. They do not wait for a boundary.
- Restart: a `restart` pulse sets `restart_pend`. At the next boundary, in any state:
  - `hoffset` is set to `OFFSET_MAX` and the divider is set to 0.
  - `restart_pend` is cleared.
  - No step is applied in that frame.
  - The FSM state is unchanged.
- Divider: on each boundary in RUN, `div` increments. When `div == FRAMES_PER_STEP-1`, an update fires and `div` returns to 0. The divider is frozen in IDLE and PAUSE.
- Update arithmetic:
  - `speed` is sampled at the update cycle.
  - `next = hoffset - speed` is computed in OFFSET_W+1 signed bits, so it cannot overflow.
  - If `next < OFFSET_MIN`, then `hoffset` is set to `OFFSET_MAX` and `wrap` pulses. Otherwise `hoffset` is set to `next`.
  - `speed==0`: no change and no `wrap`.
- Priority at a boundary: `rst` > `restart_pend` > update.

## Timing
- Reset values:
  - `hoffset=OFFSET_MAX`, `frame_tick=0`, `wrap=0`, `running=0`
  - state IDLE, `div=0`, `restart_pend=0`
  - `vsync_q=1`, so a spurious boundary cannot occur on the first cycle after reset
- Latency: a falling edge is seen in cycle n (`vsync` low, `vsync_q` high). In cycle n+1, `frame_tick`, `wrap` and the new `hoffset` are all visible together.
- `hoffset` changes only in the cycle after a boundary, or on `rst`. It is stable for the rest of the frame.
- `frame_tick` pulses on every boundary, in every state.
- `running` is registered and follows the FSM state one cycle after `enable` changes.
- `restart` and a boundary in the same cycle: the restart applies at that boundary.
- `rst` asserted mid-frame: all registers take their reset values at the next edge. There is no boundary detection while `rst` is high.

## Configuration
- Macro: `SCROLL_PINGPONG_EN`.
- Defined: an internal `dir` bit is added (reset 0 = decreasing).
  - Decreasing: when `hoffset - speed < OFFSET_MIN`, `hoffset` is clamped to `OFFSET_MIN`, `dir` is set to 1, and `wrap` pulses.
  - Increasing: `hoffset + speed` is computed. If it is greater than `OFFSET_MAX`, `hoffset` is clamped to `OFFSET_MAX`, `dir` is set to 0, and `wrap` pulses.
  - `restart` also clears `dir`.
- Undefined: `dir` is absent and the wrap-to-`OFFSET_MAX` behaviour above applies. Port list is identical in both builds.

## Test plan
- Reset, with `vsync` toggling and `enable=0`, for 5 frames -> `hoffset` stays 600, `frame_tick` pulses 5 times, `running=0`.
- `enable=1`, `speed=1`, `FRAMES_PER_STEP=1`, 3 frames -> `hoffset` is 599, 598, 597, each appearing 1 cycle after the `vsync` falling edge and constant mid-frame.
- Preload by running to `hoffset=-599`, `speed=2`, one frame -> `hoffset=600`, `wrap` high exactly one cycle. Separately, `hoffset=-598`, `speed=2` -> -600 with no `wrap`.
- `FRAMES_PER_STEP=3`, `speed=5`, 6 frames -> changes only on the 3rd and 6th boundaries (600 → 595 → 590). Deassert `enable` after the 4th frame -> value frozen, divider resumes from 1 on re-enable.
- `restart` pulse mid-frame at `hoffset=100` -> still 100 until the next boundary, then 600 with no step applied. `rst` mid-frame -> `hoffset=600` next cycle and IDLE.
- With `SCROLL_PINGPONG_EN`: at `hoffset=-599`, `speed=3` -> -600 with `wrap`, then -597, -594 on subsequent frames.
